mux16_1bit_rr_arbiter: RTL and testbench
========================================

MUX16_1BIT_RR_ARBITER -- requirements
Module: mux16_1bit_rr_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, max cycles in WAIT_ACK before abort; legal range 1..65535.
REQ-002 Parameter PARK_SEL, default 5'h10, sel value driven when no channel is granted; SHALL be >= 16 so a downstream 1:16 demux drives def_value on every output.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  arbitration enable; 0 blocks new grants and never aborts a grant in progress.
REQ-006 def_value  input  1  value driven on output_port when no channel is granted.
REQ-007 req_in  input  16  per-channel request, level-sensitive, bit n = channel n.
REQ-008 data_in  input  16  per-channel 1-bit data, bit n = channel n.
REQ-009 ack_in  input  1  single-cycle completion strobe from the consumer of the granted channel.
REQ-010 sel  output  5  granted channel index 0..15, or PARK_SEL when idle.
REQ-011 output_port  output  1  data_in[sel] while granted, else def_value.
REQ-012 grant  output  1  one-cycle pulse on the first cycle a new sel is valid.
REQ-013 busy  output  1  high in GRANT, WAIT_ACK and RELEASE.
REQ-014 timeout_err  output  1  one-cycle pulse when a grant is aborted by timeout.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT, WAIT_ACK and RELEASE.
REQ-016 IDLE: if enable=1 and req_in!=0, register the winner into sel and go to GRANT; otherwise stay in IDLE with sel=PARK_SEL.
REQ-017 Winner: first set bit of req_in searching upward from rr_ptr with wrap 15->0; rr_ptr is 4 bits and resets to 0.
REQ-018 GRANT: grant=1 for exactly this cycle, clear the timeout counter, go to WAIT_ACK unconditionally.
REQ-019 WAIT_ACK: if ack_in=1, go to RELEASE; else if the counter equals TIMEOUT_CYCLES-1, pulse timeout_err and go to RELEASE; else increment the counter.
REQ-020 ack_in and timeout in the same cycle SHALL count as ack, with no timeout_err.
REQ-021 ack_in outside WAIT_ACK SHALL be ignored.
REQ-022 RELEASE: set rr_ptr = sel[3:0]+1 mod 16, set sel=PARK_SEL, return to IDLE; one-cycle gap between grants.
REQ-023 Latency: request seen in IDLE at edge k -> grant and sel valid after edge k+1.
REQ-024 output_port SHALL be combinational from the registered sel and data_in: data_in[sel[3:0]] when sel<16, else def_value.
REQ-025 Deasserting req_in of the granted channel mid-grant SHALL NOT cancel it; only ack_in or timeout ends a grant.
REQ-026 Deasserting enable mid-grant SHALL let the grant complete normally.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, sel=PARK_SEL, rr_ptr=0, counter=0, grant=0, busy=0, timeout_err=0.
REQ-028 Reset asserted mid-grant SHALL abandon the grant with no timeout_err pulse.
REQ-029 After rst falls, the first grant is possible at the second rising edge.

Structure
REQ-030 The FSM state encoding, PARK_SEL default and channel count (16) SHALL live in the shared mopshub package.
REQ-031 The round-robin priority search SHALL be one combinational sub-module, rr_prio_find16 (inputs: req[15:0], ptr[3:0]; outputs: idx[3:0], found).

Verification
REQ-032 Reset release, req_in=16'h0 for 20 cycles -> sel=5'h10, output_port tracks def_value, busy=0, grant never pulses.
REQ-033 req_in=16'h8001, ack_in 3 cycles after each grant -> grants to sel=0, then 15, then 0; exactly one idle cycle between each RELEASE and the next grant.
REQ-034 req_in=16'h0010, TIMEOUT_CYCLES=8, no ack -> timeout_err pulses exactly 8 cycles after grant; sel returns to 5'h10; rr_ptr=5.
REQ-035 Grant on channel 3 with data_in[3] toggled each cycle -> output_port follows data_in[3] during WAIT_ACK; ack_in and timeout in the same cycle -> no timeout_err.
REQ-036 rst asserted in WAIT_ACK between clock edges -> outputs reach reset values immediately, without waiting for a clock edge, and no timeout_err pulse.
REQ-037 enable=0 with req_in=16'hFFFF -> no grant; enable dropped mid-grant -> the current grant finishes on ack_in, and no new grant follows.

Source files
------------

// File: rtl/mopshub_pkg.sv
// Shared definitions for the mopshub 16:1 round-robin arbiter.
// Holds the channel count, select width, idle select value and arbiter state encoding.
package mopshub_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned CH_W   = 4;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned CNT_W  = 16;

  // Any select value >= NUM_CH parks a downstream 1:16 demux on its default value.
  localparam logic [SEL_W-1:0] PARK_SEL_DEFAULT = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_e;

  function automatic logic [CH_W-1:0] rr_next_ptr(input logic [CH_W-1:0] idx);
    return idx + CH_W'(1);
  endfunction

endpackage

// File: rtl/rr_prio_find16.sv
// Round-robin priority search: first set request bit at or above ptr, wrapping 15 -> 0.
// Purely combinational.
module rr_prio_find16
  import mopshub_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   idx,
  output logic              found
);

  logic [CH_W-1:0] cand [NUM_CH];

  // cand[i] is the channel at distance i from the pointer; the add wraps modulo 16.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cand
    assign cand[i] = ptr + CH_W'(i);
  end

  always_comb begin
    // NOTE: defaults first so every path assigns idx/found and no latch is inferred.
    idx   = '0;
    found = 1'b0;
    // Walk from the farthest candidate down so the nearest requester is written last.
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        idx   = cand[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux16_1bit_rr_arbiter.sv
// 16-channel 1-bit round-robin arbitrated mux with ack handshake and grant timeout.
// PARK_SEL must be >= 16 so the idle select falls outside the channel range.
module mux16_1bit_rr_arbiter
  import mopshub_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYCLES = 1000,
  parameter logic [SEL_W-1:0] PARK_SEL       = PARK_SEL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              def_value,
  input  logic [NUM_CH-1:0] req_in,
  input  logic [NUM_CH-1:0] data_in,
  input  logic              ack_in,
  output logic [SEL_W-1:0]  sel,
  output logic              output_port,
  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q;
  logic [SEL_W-1:0] sel_q;
  logic [CH_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_q;
  logic             busy_q;
  logic             armed_q;

  logic [CH_W-1:0]  win_idx;
  logic             win_found;
  logic             timeout_hit;

  rr_prio_find16 u_prio (
    .req   (req_in),
    .ptr   (rr_ptr_q),
    .idx   (win_idx),
    .found (win_found)
  );

  assign timeout_hit = (state_q == ST_WAIT_ACK) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= PARK_SEL;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      busy_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees the pre-edge register values.
      grant_q <= 1'b0;
      // The first edge after reset release only arms the arbiter; grants start one edge later.
      armed_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (armed_q && enable && win_found) begin
            sel_q   <= SEL_W'(win_idx);
            grant_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (ack_in || timeout_hit) begin
            state_q <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          rr_ptr_q <= rr_next_ptr(sel_q[CH_W-1:0]);
          sel_q    <= PARK_SEL;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

  // Decoded from state so the pulse lands in the last WAIT_ACK cycle and an ack in that cycle masks it.
  assign timeout_err = timeout_hit && !ack_in;

  assign output_port = (sel_q < SEL_W'(NUM_CH)) ? data_in[sel_q[CH_W-1:0]] : def_value;

endmodule

// File: tb/tb_mux16_1bit_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mux16_1bit_rr_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        def_value;
  logic [15:0] req_in;
  logic [15:0] data_in;
  logic        ack_in;
  logic [4:0]  sel;
  logic        output_port;
  logic        grant;
  logic        busy;
  logic        timeout_err;

  mux16_1bit_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .def_value   (def_value),
    .req_in      (req_in),
    .data_in     (data_in),
    .ack_in      (ack_in),
    .sel         (sel),
    .output_port (output_port),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner channel (-1 = none), cycles since the grant pulse, a
  // release-pending flag and the round-robin start channel.
  int m_owner  = -1;
  int m_age    = 0;
  int m_ptr    = 0;
  bit m_ending = 1'b0;
  bit m_armed  = 1'b0;

  function automatic int rr_pick(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner  <= -1;
      m_age    <= 0;
      m_ptr    <= 0;
      m_ending <= 1'b0;
      m_armed  <= 1'b0;
    end else begin
      m_armed <= 1'b1;
      if (m_owner < 0) begin
        if (m_armed && enable && req_in != 16'h0) begin
          m_owner  <= rr_pick(req_in, m_ptr);
          m_age    <= 0;
          m_ending <= 1'b0;
        end
      end else if (m_ending) begin
        m_ptr    <= (m_owner + 1) % 16;
        m_owner  <= -1;
        m_ending <= 1'b0;
      end else if (m_age == 0) begin
        m_age <= 1;
      end else if (ack_in || m_age == TO) begin
        m_ending <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  int           cyc = 0;
  int           to_count = 0;
  int           last_to_cyc = 0;
  logic [4:0]   grant_sel[$];
  int           grant_cyc[$];

  task automatic check_outputs();
    logic [4:0] e_sel;
    logic       e_busy, e_grant, e_to, e_out;
    bit         in_wait;
    in_wait = (m_owner >= 0) && !m_ending && (m_age >= 1);
    e_sel   = (m_owner >= 0) ? 5'(m_owner) : 5'h10;
    e_busy  = (m_owner >= 0);
    e_grant = (m_owner >= 0) && !m_ending && (m_age == 0);
    e_to    = in_wait && (m_age == TO) && !ack_in;
    e_out   = (m_owner >= 0) ? data_in[m_owner] : def_value;
    check("sel", 32'(sel), 32'(e_sel));
    check("busy", 32'(busy), 32'(e_busy));
    check("grant", 32'(grant), 32'(e_grant));
    check("timeout_err", 32'(timeout_err), 32'(e_to));
    check("output_port", 32'(output_port), 32'(e_out));
    cyc++;
    if (grant === 1'b1) begin
      grant_sel.push_back(sel);
      grant_cyc.push_back(cyc);
    end
    if (timeout_err === 1'b1) begin
      to_count++;
      last_to_cyc = cyc;
    end
  endtask

  int ack_at    = 0;
  bit rand_data = 1'b0;
  bit rand_ack  = 1'b0;

  // Inputs change 1 time unit after the rising edge, outputs are compared on the falling edge.
  task automatic tick();
    if (rand_data) begin
      data_in   = 16'($urandom);
      def_value = 1'($urandom);
    end
    if (rand_ack) ack_in = ($urandom_range(0, 4) == 0);
    else          ack_in = (ack_at > 0) && (m_owner >= 0) && !m_ending && (m_age == ack_at);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until_grant(input int max, input string tag);
    int start;
    int k;
    start = grant_cyc.size();
    k = 0;
    while (grant_cyc.size() == start && k < max) begin
      tick();
      k++;
    end
    check(tag, 32'(grant_cyc.size() > start), 32'd1);
  endtask

  task automatic run_until_timeout(input int max, input string tag);
    int start;
    int k;
    start = to_count;
    k = 0;
    while (to_count == start && k < max) begin
      tick();
      k++;
    end
    check(tag, 32'(to_count > start), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_to;
    int base_g;
    int c0;

    rst = 1'b1; enable = 1'b0; def_value = 1'b0; ack_in = 1'b0;
    req_in = 16'h0; data_in = 16'h0;
    run(3);
    check("rst_sel", 32'(sel), 32'h10);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Idle with no requests: parked select, output follows def_value.
    enable = 1'b1;
    rand_data = 1'b1;
    run(20);
    check("idle_no_grant", 32'(grant_cyc.size()), 32'd0);
    rand_data = 1'b0;

    // Two requesters alternate; ack three cycles after each grant.
    grant_sel.delete(); grant_cyc.delete();
    req_in = 16'h8001; ack_at = 3;
    run(20);
    check("rr_count", 32'(grant_sel.size() >= 3), 32'd1);
    if (grant_sel.size() >= 3) begin
      check("rr_g0", 32'(grant_sel[0]), 32'd0);
      check("rr_g1", 32'(grant_sel[1]), 32'd15);
      check("rr_g2", 32'(grant_sel[2]), 32'd0);
      // grant, 3 wait cycles, release, one idle cycle
      check("rr_gap01", 32'(grant_cyc[1] - grant_cyc[0]), 32'd6);
      check("rr_gap12", 32'(grant_cyc[2] - grant_cyc[1]), 32'd6);
    end
    req_in = 16'h0;
    run(10);

    // No ack: timeout on channel 4, pointer then starts at 5.
    grant_sel.delete(); grant_cyc.delete();
    req_in = 16'h0010; ack_at = 0;
    run_until_grant(10, "to_grant");
    run_until_timeout(20, "to_seen");
    req_in = 16'h0;
    if (grant_cyc.size() >= 1) check("to_delay", 32'(last_to_cyc - grant_cyc[0]), 32'(TO));
    run(2);
    check("to_park_sel", 32'(sel), 32'h10);
    check("to_park_busy", 32'(busy), 32'd0);
    req_in = 16'hFFFF; ack_at = 2;
    run_until_grant(5, "ptr_grant");
    check("ptr_after_to", 32'(grant_sel[$]), 32'd5);
    req_in = 16'h0;
    run(8);

    // Channel 3 with toggling data; ack coincides with the timeout cycle; request dropped mid-grant.
    base_to = to_count;
    req_in = 16'h0008; rand_data = 1'b1; ack_at = TO;
    run_until_grant(5, "ch3_grant");
    check("ch3_sel", 32'(grant_sel[$]), 32'd3);
    req_in = 16'h0;
    run(TO + 3);
    check("ack_beats_to", 32'(to_count - base_to), 32'd0);
    check("ch3_done", 32'(busy), 32'd0);
    rand_data = 1'b0;

    // Asynchronous reset mid WAIT_ACK.
    base_to = to_count;
    def_value = 1'b1;
    req_in = 16'h0010; ack_at = 0;
    run_until_grant(5, "ar_grant");
    run(3);
    #3;
    rst = 1'b1;
    #1;
    check("ar_sel", 32'(sel), 32'h10);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_to", 32'(timeout_err), 32'd0);
    check("ar_out", 32'(output_port), 32'(def_value));
    run(2);
    rst = 1'b0;
    req_in = 16'h0001; ack_at = 2;
    c0 = cyc;
    base_g = grant_cyc.size();
    run(4);
    req_in = 16'h0;
    run(8);
    check("ar_no_to", 32'(to_count - base_to), 32'd0);
    check("first_grant_seen", 32'(grant_cyc.size() > base_g), 32'd1);
    if (grant_cyc.size() > base_g) check("first_grant_cyc", 32'(grant_cyc[base_g] - c0), 32'd3);

    // Disabled arbiter ignores requests; dropping enable mid-grant lets it finish.
    base_to = to_count;
    enable = 1'b0; req_in = 16'hFFFF; ack_at = 5;
    base_g = grant_cyc.size();
    run(10);
    check("dis_no_grant", 32'(grant_cyc.size() - base_g), 32'd0);
    enable = 1'b1;
    run_until_grant(5, "en_grant");
    enable = 1'b0;
    base_g = grant_cyc.size();
    run(15);
    check("en_drop_no_new", 32'(grant_cyc.size() - base_g), 32'd0);
    check("en_drop_done", 32'(busy), 32'd0);
    check("en_drop_no_to", 32'(to_count - base_to), 32'd0);

    // Random traffic against the model.
    rand_data = 1'b1; rand_ack = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req_in = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 15) == 0) req_in = 16'h0;
      enable = ($urandom_range(0, 7) != 0);
      tick();
    end
    check("rand_grants", 32'(grant_cyc.size() > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
